// File: rtl/lfsr_burst_gen.sv
// XNOR-feedback Fibonacci LFSR with free-run and fixed-length burst stepping,
// period measurement against the loaded seed, and all-ones lockup recovery.
module lfsr_burst_gen #(
    parameter int                  NUM_BITS = 8,
    parameter logic [NUM_BITS-1:0] TAPS     = '0,
    parameter int                  CNT_W    = 16
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    input  logic                i_Enable,
    input  logic                i_Seed_DV,
    input  logic [NUM_BITS-1:0] i_Seed_Data,
    input  logic                i_Burst_Start,
    input  logic [CNT_W-1:0]    i_Burst_Len,
    output logic [NUM_BITS-1:0] o_LFSR_Data,
    output logic                o_LFSR_Valid,
    output logic                o_Wrap,
    output logic [NUM_BITS:0]   o_Period,
    output logic                o_Lockup,
    output logic                o_Busy,
    output logic                o_Burst_Done
);

    // Maximal-length XNOR taps; bit k of the mask is tap k+1.
    function automatic logic [15:0] table_mask(input int n);
        case (n)
            3:       return 16'h0006;
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            16:      return 16'hD008;
            default: return 16'h0000;
        endcase
    endfunction

    localparam logic [15:0]          TABLE_MASK = table_mask(NUM_BITS);
    localparam logic [NUM_BITS-1:0]  TAP_MASK   = (TAPS != '0) ? TAPS : TABLE_MASK[NUM_BITS-1:0];

    typedef enum logic {IDLE, BURST} state_t;

    state_t              state, state_nxt;
    logic [NUM_BITS-1:0] lfsr, seed_ref, lfsr_step;
    logic [NUM_BITS:0]   step_cnt, period;
    logic [CNT_W-1:0]    remaining;
    logic                valid_q, wrap_q, lockup_q, done_q;
    logic                do_step, load_rem, done_nxt;
    logic                fb, lockup_now, hit_seed, cnt_sat;

    always_comb begin
        fb         = ~^(lfsr & TAP_MASK);
        lockup_now = &lfsr;
        lfsr_step  = lockup_now ? '0 : {lfsr[NUM_BITS-2:0], fb};
        hit_seed   = !lockup_now && (lfsr_step == seed_ref);
        cnt_sat    = &step_cnt;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        state_nxt = state;
        do_step   = 1'b0;
        load_rem  = 1'b0;
        done_nxt  = 1'b0;
        if (!i_Seed_DV) begin
            case (state)
                IDLE: begin
                    if (i_Burst_Start) begin
                        if (i_Burst_Len != '0) begin
                            state_nxt = BURST;
                            load_rem  = 1'b1;
                        end else begin
                            done_nxt = 1'b1;
                        end
                    end else begin
                        do_step = i_Enable;
                    end
                end
                BURST: begin
                    do_step = 1'b1;
                    if (remaining == CNT_W'(1)) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end else begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            lfsr      <= '0;
            seed_ref  <= '0;
            step_cnt  <= '0;
            period    <= '0;
            remaining <= '0;
            valid_q   <= 1'b0;
            wrap_q    <= 1'b0;
            lockup_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            valid_q  <= 1'b0;
            wrap_q   <= 1'b0;
            lockup_q <= 1'b0;
            done_q   <= done_nxt;
            if (i_Seed_DV) begin
                lfsr     <= i_Seed_Data;
                // All-ones can never recur, so compare against the state it recovers to.
                seed_ref <= (&i_Seed_Data) ? '0 : i_Seed_Data;
                step_cnt <= '0;
            end else if (do_step) begin
                lfsr    <= lfsr_step;
                valid_q <= 1'b1;
                if (lockup_now) begin
                    lockup_q <= 1'b1;
                end else if (hit_seed) begin
                    wrap_q   <= 1'b1;
                    period   <= cnt_sat ? step_cnt : step_cnt + 1'b1;
                    step_cnt <= '0;
                end else if (!cnt_sat) begin
                    step_cnt <= step_cnt + 1'b1;
                end
            end
            if (load_rem)
                remaining <= i_Burst_Len;
            else if (state == BURST && do_step)
                remaining <= remaining - 1'b1;
        end
    end

    assign o_LFSR_Data  = lfsr;
    assign o_LFSR_Valid = valid_q;
    assign o_Wrap       = wrap_q;
    assign o_Period     = period;
    assign o_Lockup     = lockup_q;
    assign o_Busy       = (state == BURST);
    assign o_Burst_Done = done_q;

endmodule

// File: tb/tb_lfsr_burst_gen.sv
// Scoreboard bench for lfsr_burst_gen: 3-, 8- and 16-bit instances driven in turn,
// expected output events queued by the stimulus and popped by per-instance monitors.
module tb_lfsr_burst_gen;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  flags;   // {valid, wrap, lockup, done}
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    exp_t q3[$];
    exp_t q8[$];
    bit   sb8_on = 1'b1;

    // 3-bit instance
    logic        en3 = 0, sdv3 = 0;
    logic [2:0]  sd3 = '0;
    logic [2:0]  d3;
    logic [3:0]  p3;
    logic        v3, w3, l3, b3, dn3;

    // 8-bit instance
    logic        en8 = 0, sdv8 = 0, bs8 = 0;
    logic [7:0]  sd8 = '0;
    logic [15:0] bl8 = '0;
    logic [7:0]  d8;
    logic [8:0]  p8;
    logic        v8, w8, l8, b8, dn8;

    // 16-bit instance
    logic        en16 = 0, sdv16 = 0;
    logic [15:0] sd16 = '0;
    logic [15:0] d16;
    logic [16:0] p16;
    logic        v16, w16, l16, b16, dn16;

    lfsr_burst_gen #(.NUM_BITS(3)) dut3 (
        .i_Clk(clk), .i_Rst(rst), .i_Enable(en3), .i_Seed_DV(sdv3), .i_Seed_Data(sd3),
        .i_Burst_Start(1'b0), .i_Burst_Len(16'd0),
        .o_LFSR_Data(d3), .o_LFSR_Valid(v3), .o_Wrap(w3), .o_Period(p3),
        .o_Lockup(l3), .o_Busy(b3), .o_Burst_Done(dn3)
    );

    lfsr_burst_gen #(.NUM_BITS(8)) dut8 (
        .i_Clk(clk), .i_Rst(rst), .i_Enable(en8), .i_Seed_DV(sdv8), .i_Seed_Data(sd8),
        .i_Burst_Start(bs8), .i_Burst_Len(bl8),
        .o_LFSR_Data(d8), .o_LFSR_Valid(v8), .o_Wrap(w8), .o_Period(p8),
        .o_Lockup(l8), .o_Busy(b8), .o_Burst_Done(dn8)
    );

    lfsr_burst_gen #(.NUM_BITS(16)) dut16 (
        .i_Clk(clk), .i_Rst(rst), .i_Enable(en16), .i_Seed_DV(sdv16), .i_Seed_Data(sd16),
        .i_Burst_Start(1'b0), .i_Burst_Len(16'd0),
        .o_LFSR_Data(d16), .o_LFSR_Valid(v16), .o_Wrap(w16), .o_Period(p16),
        .o_Lockup(l16), .o_Busy(b16), .o_Burst_Done(dn16)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push3(input logic [2:0] d, input logic [3:0] f);
        exp_t e;
        e.data = {13'd0, d};
        e.flags = f;
        q3.push_back(e);
    endtask

    task automatic push8(input logic [7:0] d, input logic [3:0] f);
        exp_t e;
        e.data = {8'd0, d};
        e.flags = f;
        q8.push_back(e);
    endtask

    // Monitors: any pulse output is an event that must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && (v3 || w3 || l3 || dn3)) begin
            if (q3.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL dut3 unexpected event: data=%0h flags=%b", d3, {v3, w3, l3, dn3});
            end else begin
                exp_t e;
                e = q3.pop_front();
                check("dut3 data", {29'd0, d3}, {16'd0, e.data});
                check("dut3 flags", {28'd0, v3, w3, l3, dn3}, {28'd0, e.flags});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && sb8_on && (v8 || w8 || l8 || dn8)) begin
            if (q8.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL dut8 unexpected event: data=%0h flags=%b", d8, {v8, w8, l8, dn8});
            end else begin
                exp_t e;
                e = q8.pop_front();
                check("dut8 data", {24'd0, d8}, {16'd0, e.data});
                check("dut8 flags", {28'd0, v8, w8, l8, dn8}, {28'd0, e.flags});
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] seq3 [7];
        logic [7:0] seq8 [10];
        int         busy_cnt;
        int         steps;
        bit         got;

        seq3 = '{3'd1, 3'd3, 3'd6, 3'd5, 3'd2, 3'd4, 3'd0};
        seq8 = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E, 8'h3D, 8'h7A, 8'hF4, 8'hE8, 8'hD0};

        // Reset state
        #12;
        check("reset data8", {24'd0, d8}, 32'd0);
        check("reset period8", {23'd0, p8}, 32'd0);
        check("reset pulses8", {28'd0, v8, w8, l8, dn8}, 32'd0);
        check("reset busy8", {31'd0, b8}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // 3-bit free run from seed 000: two full cycles
        sd3 = 3'd0; sdv3 = 1'b1; tick(1); sdv3 = 1'b0;
        en3 = 1'b1;
        for (int i = 0; i < 14; i++)
            push3(seq3[i % 7], (i % 7 == 6) ? 4'b1100 : 4'b1000);
        tick(14); en3 = 1'b0;
        tick(2);
        check("dut3 period", {28'd0, p3}, 32'd7);

        // 3-bit lockup recovery from seed 111
        rst = 1'b1; tick(1); rst = 1'b0; tick(1);
        check("dut3 period after reset", {28'd0, p3}, 32'd0);
        sd3 = 3'd7; sdv3 = 1'b1; tick(1); sdv3 = 1'b0;
        check("dut3 seed 111 loaded", {29'd0, d3}, 32'd7);
        en3 = 1'b1;
        push3(3'd0, 4'b1010);
        for (int i = 0; i < 7; i++)
            push3(seq3[i], (i == 6) ? 4'b1100 : 4'b1000);
        tick(8); en3 = 1'b0;
        tick(2);
        check("dut3 period after lockup", {28'd0, p3}, 32'd7);

        // 8-bit burst of 5 with enable low
        sd8 = 8'h00; sdv8 = 1'b1; tick(1); sdv8 = 1'b0;
        bl8 = 16'd5; bs8 = 1'b1;
        for (int i = 0; i < 5; i++)
            push8(seq8[i], (i == 4) ? 4'b1001 : 4'b1000);
        tick(1); bs8 = 1'b0;
        busy_cnt = 0;
        repeat (8) begin @(negedge clk); busy_cnt += int'(b8); end
        @(posedge clk); #1;
        check("burst5 busy cycles", busy_cnt, 32'd5);
        check("burst5 data holds", {24'd0, d8}, 32'h1E);

        // Burst of length 0
        bl8 = 16'd0; bs8 = 1'b1;
        push8(8'h1E, 4'b0001);
        tick(1); bs8 = 1'b0;
        busy_cnt = 0;
        repeat (4) begin @(negedge clk); busy_cnt += int'(b8); end
        @(posedge clk); #1;
        check("burst0 busy cycles", busy_cnt, 32'd0);
        check("burst0 data unchanged", {24'd0, d8}, 32'h1E);

        // Burst of 300 aborted by seed load after 10 steps
        sd8 = 8'h00; sdv8 = 1'b1; tick(1); sdv8 = 1'b0;
        bl8 = 16'd300; bs8 = 1'b1;
        for (int i = 0; i < 10; i++)
            push8(seq8[i], 4'b1000);
        tick(1); bs8 = 1'b0;
        tick(10);
        check("abort busy before load", {31'd0, b8}, 32'd1);
        sd8 = 8'h5A; sdv8 = 1'b1; tick(1); sdv8 = 1'b0;
        check("abort busy dropped", {31'd0, b8}, 32'd0);
        check("abort data is new seed", {24'd0, d8}, 32'h5A);
        tick(6);
        check("abort data holds", {24'd0, d8}, 32'h5A);
        check("dut8 scoreboard drained", q8.size(), 32'd0);

        // 8-bit free run period
        sb8_on = 1'b0;
        sd8 = 8'h00; sdv8 = 1'b1; tick(1); sdv8 = 1'b0;
        en8 = 1'b1;
        got = 1'b0; steps = 0;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk);
            if (v8) steps++;
            if (w8) got = 1'b1;
        end
        en8 = 1'b0;
        check("dut8 wrap seen", {31'd0, got}, 32'd1);
        check("dut8 steps to wrap", steps, 32'd255);
        check("dut8 period", {23'd0, p8}, 32'd255);
        check("dut8 data at wrap", {24'd0, d8}, 32'd0);
        @(posedge clk); #1;

        // 16-bit free run period
        sd16 = 16'h0000; sdv16 = 1'b1; tick(1); sdv16 = 1'b0;
        en16 = 1'b1;
        got = 1'b0; steps = 0;
        for (int c = 0; c < 70000 && !got; c++) begin
            @(negedge clk);
            if (v16) steps++;
            if (w16) got = 1'b1;
        end
        en16 = 1'b0;
        check("dut16 wrap seen", {31'd0, got}, 32'd1);
        check("dut16 steps to wrap", steps, 32'd65535);
        check("dut16 period", {15'd0, p16}, 32'd65535);
        @(posedge clk); #1;

        // Async reset in the middle of a burst
        sd8 = 8'h00; sdv8 = 1'b1; tick(1); sdv8 = 1'b0;
        bl8 = 16'd300; bs8 = 1'b1; tick(1); bs8 = 1'b0;
        tick(20);
        check("midburst busy", {31'd0, b8}, 32'd1);
        check("midburst valid", {31'd0, v8}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async reset data8", {24'd0, d8}, 32'd0);
        check("async reset pulses8", {28'd0, v8, w8, l8, dn8}, 32'd0);
        check("async reset busy8", {31'd0, b8}, 32'd0);
        check("async reset period8", {23'd0, p8}, 32'd0);
        check("async reset period16", {15'd0, p16}, 32'd0);
        tick(2); rst = 1'b0;
        tick(3);
        check("idle after reset busy8", {31'd0, b8}, 32'd0);
        check("dut3 scoreboard drained", q3.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lfsr_burst_gen.md
Name: lfsr_burst_gen

Overview:
Parametrised XNOR-feedback Fibonacci LFSR and the next generation of the team's single-width LFSR.
- Widths of 3..16 bits use a built-in maximal-length tap table; a mask parameter can override the table.
- Adds free-run and fixed-length burst modes, period measurement against the loaded seed, and all-ones lockup recovery.
- Feeds pseudo-random test patterns and scrambler sequences to downstream datapath blocks.

Parameters:
NUM_BITS, 8, LFSR width; legal range 3..16.
TAPS, 0, tap mask override; bit k set means tap k+1 (1-indexed); 0 selects the built-in table.
CNT_W, 16, width of burst length input.

Ports:
i_Clk  in  1  clock, rising edge.
i_Rst  in  1  asynchronous, active-high reset.
i_Enable  in  1  step once per cycle while in IDLE state.
i_Seed_DV  in  1  load i_Seed_Data this cycle.
i_Seed_Data  in  NUM_BITS  seed value.
i_Burst_Start  in  1  start a burst of i_Burst_Len steps.
i_Burst_Len  in  CNT_W  burst step count, sampled with i_Burst_Start.
o_LFSR_Data  out  NUM_BITS  current LFSR state.
o_LFSR_Valid  out  1  pulse: o_LFSR_Data updated by a step this cycle.
o_Wrap  out  1  pulse: state returned to stored seed.
o_Period  out  NUM_BITS+1  step count of last completed cycle (latched).
o_Lockup  out  1  pulse: all-ones lockup state was recovered.
o_Busy  out  1  high while in BURST state.
o_Burst_Done  out  1  pulse after the final burst step.

Behaviour:
- Reset (async assert, synchronous release):
  - State, stored seed, step counter, o_Period all 0.
  - All pulse outputs 0; o_Busy 0; FSM enters IDLE.
- Tap table (1-indexed XNOR taps):
  - 3:3,2. 4:4,3. 5:5,3. 6:6,5. 7:7,6. 8:8,6,5,4. 9:9,5. 10:10,7.
  - 11:11,9. 12:12,6,4,1. 13:13,4,3,1. 14:14,5,3,1. 15:15,14. 16:16,15,13,4.
- Step: fb = XNOR of tapped bits; next state = {state[NUM_BITS-2:0], fb}.
  - All registers update on the stepping edge.
  - o_LFSR_Valid is high for exactly the cycle following each step edge.
- Priority per edge: reset > seed load > burst start > step.
- Seed load:
  - State and stored seed take i_Seed_Data; step counter clears; no Valid pulse.
  - In BURST: aborts the burst, FSM goes to IDLE, no o_Burst_Done.
- FSM states:
  - IDLE: steps when i_Enable is 1.
    - i_Burst_Start with Len>0 goes to BURST with remaining count = Len.
    - Len=0 gives an o_Burst_Done pulse next cycle, no step, stays in IDLE.
  - BURST: steps every cycle regardless of i_Enable; remaining count decrements per step.
    - On the step where remaining reaches 0: go to IDLE, o_Burst_Done pulses the following cycle (same cycle as the last Valid).
    - i_Burst_Start while BURST is ignored.
- Period:
  - Step counter increments on each normal step.
  - When the next state equals the stored seed: o_Wrap pulses, o_Period gets counter+1, counter clears.
  - Counter saturates at all-ones with no wrap.
- Lockup: a step from all-ones state yields all-zeros.
  - o_Lockup pulses; the step counts as Valid.
  - The step does not increment the counter or produce a wrap.
  - A seed of all-ones is stored as all-zeros for wrap comparison.
- i_Enable ignored during BURST and during seed load.

Test Plan:
- NUM_BITS=3, reset, seed 000, i_Enable=1 for 14 cycles -> Data 1,3,6,5,2,4,0,1,...; o_Wrap pulses with Data=0 after step 7; o_Period=7.
- NUM_BITS=3, seed 111, enable 2 steps -> Data 0 with o_Lockup pulse, then 1; no o_Wrap; counter unchanged by the recovery step.
- NUM_BITS=8, seed 00, i_Enable=0, burst Len=5 -> 5 consecutive Valid pulses, o_Busy high 5 cycles, o_Burst_Done coincides with the 5th Valid; Data then holds.
- Burst Len=0 -> o_Burst_Done one cycle later, no Valid, o_Busy stays 0.
- NUM_BITS=8, burst Len=300 with seed load at step 10 -> o_Busy drops, no o_Burst_Done, Data = new seed.
- NUM_BITS=8 and 16, free-run from seed 0 -> o_Period = 255 and 65535; async reset mid-burst clears all outputs immediately.
